// File: rtl/line_mem_requester_if.sv
// CPU-side request/response handshake of the line-memory requester.
// master = execute stage, slave = requester.
interface line_mem_requester_if #(
    parameter int MEM_AW = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [MEM_AW+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/line_mem_requester.sv
// Turns byte/half/word CPU loads and stores into 32-bit word accesses on a
// line memory without byte enables; sub-word stores use read-modify-write.
module line_mem_requester #(
    parameter int MEM_AW = 14,
    parameter int DW     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    line_mem_requester_if.slave  bus,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] MERGE = 3'd2;
    localparam logic [2:0] WR    = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [MEM_AW+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              we_q, we_d;
    logic [31:0]       sdata_q, sdata_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              acc_err_s;
    logic [4:0]        shift_s;
    logic [31:0]       lane_s;
    logic [31:0]       mask_s;

    assign acc_err_s = (bus.req_size == 2'd3)
                     | ((bus.req_size == 2'd1) & bus.req_addr[0])
                     | ((bus.req_size == 2'd2) & (bus.req_addr[1:0] != 2'd0));
    assign shift_s   = {addr_q[1:0], 3'b000};
    assign lane_s    = mem_rdata >> shift_s;
    assign mask_s    = ((size_q == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << shift_s;

    // Next-state and datapath for the one outstanding transaction.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        we_d     = we_q;
        sdata_d  = sdata_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    we_d     = bus.req_we;
                    sdata_d  = bus.req_wdata;
                    rdata_d  = 32'd0;
                    err_d    = acc_err_s;
                    if (acc_err_s) begin
                        state_d = RESP;
                    end else if (bus.req_we && (bus.req_size == 2'd2)) begin
                        wdata_d = bus.req_wdata;
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: state_d = MERGE;
            MERGE: begin
                if (we_q) begin
                    // Only the addressed lane(s) take store data; the rest keeps memory.
                    wdata_d = (mem_rdata & ~mask_s) | ((sdata_q << shift_s) & mask_s);
                    state_d = WR;
                end else begin
                    case (size_q)
                        2'd0:    rdata_d = {{24{signed_q & lane_s[7]}}, lane_s[7:0]};
                        2'd1:    rdata_d = {{16{signed_q & lane_s[15]}}, lane_s[15:0]};
                        default: rdata_d = lane_s;
                    endcase
                    state_d = RESP;
                end
            end
            WR: state_d = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            sdata_q  <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            we_q     <= we_d;
            sdata_q  <= sdata_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Gating with rst_n kills an in-flight access as soon as reset is asserted.
    assign mem_en     = rst_n & ((state_q == RD) | (state_q == WR));
    assign mem_we     = rst_n & (state_q == WR);
    assign mem_addr   = addr_q[MEM_AW+1:2];
    assign mem_wdata  = wdata_q;

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
